// File: rtl/mem_wb_responder.sv
// Wishbone slave in front of a 2^ADDR_W x 32-bit RAM with classic and
// incrementing-burst support, configurable read latency and range error.
module mem_wb_responder #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic        clkcpu,
    input  logic        rst_i,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [2:0]  wb_cti,
    input  logic [21:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        wb_err
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned LAT_INIT = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
    localparam logic [2:0]  CTI_INCR = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        XFER,
        ERR
    } state_t;

    state_t            state, state_n;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] cnt, cnt_n, rd_addr;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
    logic              we_q, we_n;
    logic              burst_q, burst_n;
    logic              ack_n, err_n;
    logic [31:0]       dat_n;
    logic              load_dat;
    logic              wr_en;
    logic              req;
    logic              out_of_range;

    assign req          = wb_cyc & wb_stb;
    assign out_of_range = (wb_adr >> ADDR_W) != '0;

    // Next-state, beat bookkeeping and read-data selection
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lat_cnt_n = lat_cnt;
        we_n      = we_q;
        burst_n   = burst_q;
        ack_n     = 1'b0;
        err_n     = 1'b0;
        rd_addr   = cnt;
        load_dat  = 1'b0;
        wr_en     = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    we_n    = wb_we;
                    burst_n = (wb_cti == CTI_INCR);
                    cnt_n   = wb_adr[ADDR_W-1:0];
                    rd_addr = wb_adr[ADDR_W-1:0];
                    if (out_of_range) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end else if (wb_we || RD_WAIT == 0) begin
                        state_n  = XFER;
                        ack_n    = 1'b1;
                        load_dat = !wb_we;
                    end else begin
                        state_n   = LAT;
                        lat_cnt_n = LAT_W'(LAT_INIT);
                    end
                end
            end
            LAT: begin
                if (!wb_cyc) begin
                    state_n = IDLE;
                end else if (lat_cnt == '0) begin
                    state_n  = XFER;
                    ack_n    = wb_stb;
                    load_dat = wb_stb;
                end else begin
                    lat_cnt_n = lat_cnt - 1'b1;
                end
            end
            XFER: begin
                if (!wb_cyc) begin
                    state_n = IDLE;
                end else if (wb_ack && wb_stb) begin
                    // Beat completes on this edge; prefetch the next word.
                    wr_en = we_q;
                    if (!burst_q || wb_cti != CTI_INCR) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n    = cnt + 1'b1;
                        rd_addr  = cnt + 1'b1;
                        ack_n    = 1'b1;
                        load_dat = !we_q;
                    end
                end else begin
                    ack_n    = wb_stb;
                    load_dat = wb_stb & !we_q;
                end
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        dat_n = load_dat ? mem[rd_addr] : wb_dat_o;
    end

    // Control state and registered bus outputs
    always_ff @(posedge clkcpu or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_cnt  <= '0;
            we_q     <= 1'b0;
            burst_q  <= 1'b0;
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lat_cnt  <= lat_cnt_n;
            we_q     <= we_n;
            burst_q  <= burst_n;
            wb_ack   <= ack_n;
            wb_err   <= err_n;
            wb_dat_o <= dat_n;
        end
    end

    // RAM contents survive reset; only acked write beats land
    always_ff @(posedge clkcpu) begin
        if (wr_en && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel[b]) begin
                    mem[cnt][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_responder.sv
// Directed bench for mem_wb_responder: classic, burst, wrap, error, stall and reset cases.
module tb_mem_wb_responder;

    logic        clkcpu = 1'b0;
    logic        rst_i;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [21:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_responder #(.ADDR_W(14), .RD_WAIT(1)) dut (
        .clkcpu(clkcpu), .rst_i(rst_i),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_cti(wb_cti), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clkcpu = ~clkcpu;

    task automatic bus_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_sel = 4'h0; wb_cti = 3'b000; wb_adr = '0; wb_dat_i = '0;
    endtask

    // Edge count from request to ack (99 when no ack within budget)
    task automatic wait_ack(output int lat);
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clkcpu); #1;
            if (wb_ack) begin lat = i; break; end
        end
    endtask

    task automatic write_classic(input logic [21:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, output int lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_cti = 3'b000;
        wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
        wait_ack(lat);
        @(posedge clkcpu); #1;
        bus_idle();
    endtask

    task automatic read_classic(input logic [21:0] adr, output logic [31:0] dat,
                                output int lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_cti = 3'b000;
        wb_adr = adr; wb_sel = 4'hF;
        wait_ack(lat);
        dat = wb_dat_o;
        @(posedge clkcpu); #1;
        bus_idle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus_idle();
        #12;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", wb_ack); end
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", wb_err); end
        n_cmp++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
        @(posedge clkcpu); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        logic [31:0] d;
        write_classic(22'h10, 32'hDEADBEEF, 4'hF, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency got %0d want 1", lat); end
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_drop got %b want 0", wb_ack); end
        read_classic(22'h10, d, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency got %0d want 2", lat); end
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", d); end
    endtask

    task automatic test_byte_sel();
        int lat;
        logic [31:0] d;
        write_classic(22'h10, 32'h000000AA, 4'b0001, lat);
        read_classic(22'h10, d, lat);
        n_cmp++; if (d !== 32'hDEADBEAA) begin n_bad++; $display("FAIL sel0001 got %h want deadbeaa", d); end
        write_classic(22'h10, 32'h55FFFFFF, 4'b1000, lat);
        read_classic(22'h10, d, lat);
        n_cmp++; if (d !== 32'h55ADBEAA) begin n_bad++; $display("FAIL sel1000 got %h want 55adbeaa", d); end
    endtask

    task automatic test_read_burst();
        int lat;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) write_classic(22'(i), 32'h100 + 32'(i), 4'hF, lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_cti = 3'b010; wb_adr = 22'h0;
        wait_ack(lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL burst_first_lat got %0d want 2", lat); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL burst_ack%0d got %b want 1", i, wb_ack); end
            n_cmp++; if (wb_dat_o !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL burst_dat%0d got %h want %h", i, wb_dat_o, 32'h100 + 32'(i)); end
            @(posedge clkcpu); #1;
            wb_adr = 22'(i + 1);
            if (i == 2) wb_cti = 3'b111;
        end
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL burst_end_ack got %b want 0", wb_ack); end
        bus_idle();
        read_classic(22'h2, d, lat);
        n_cmp++; if (lat !== 2 || d !== 32'h102) begin n_bad++; $display("FAIL burst_idle_after got lat %0d dat %h want 2 102", lat, d); end
    endtask

    task automatic test_wrap();
        int lat;
        write_classic(22'h3FFF, 32'hA5A50001, 4'hF, lat);
        write_classic(22'h0000, 32'h5A5A0002, 4'hF, lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_cti = 3'b010; wb_adr = 22'h3FFF;
        wait_ack(lat);
        n_cmp++; if (wb_dat_o !== 32'hA5A50001) begin n_bad++; $display("FAIL wrap_beat0 got %h want a5a50001", wb_dat_o); end
        @(posedge clkcpu); #1;
        wb_cti = 3'b111;
        n_cmp++; if (wb_ack !== 1'b1 || wb_dat_o !== 32'h5A5A0002) begin n_bad++; $display("FAIL wrap_beat1 got ack %b dat %h want 1 5a5a0002", wb_ack, wb_dat_o); end
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL wrap_err got %b want 0", wb_err); end
        @(posedge clkcpu); #1;
        bus_idle();
    endtask

    task automatic test_error();
        int lat;
        logic [31:0] d;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_cti = 3'b000;
        wb_adr = 22'h200000; wb_sel = 4'hF; wb_dat_i = 32'hFFFFFFFF;
        @(posedge clkcpu); #1;
        n_cmp++; if (wb_err !== 1'b1 || wb_ack !== 1'b0) begin n_bad++; $display("FAIL err_assert got err %b ack %b want 1 0", wb_err, wb_ack); end
        bus_idle();
        @(posedge clkcpu); #1;
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle got %b want 0", wb_err); end
        read_classic(22'h0, d, lat);
        n_cmp++; if (d !== 32'h5A5A0002) begin n_bad++; $display("FAIL err_ram_intact got %h want 5a5a0002", d); end
    endtask

    task automatic test_write_stall_abort();
        int lat;
        logic [31:0] d;
        write_classic(22'h23, 32'h12345678, 4'hF, lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_cti = 3'b010;
        wb_adr = 22'h20; wb_sel = 4'hF; wb_dat_i = 32'hD0D0D0D0;
        wait_ack(lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wburst_lat got %0d want 1", lat); end
        @(posedge clkcpu); #1;
        wb_adr = 22'h21; wb_dat_i = 32'hD1D1D1D1;
        @(posedge clkcpu); #1;
        wb_stb = 1'b0; wb_dat_i = 32'hBADBAD00;
        @(posedge clkcpu); #1;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL stall_ack got %b want 0", wb_ack); end
        @(posedge clkcpu); #1;
        wb_stb = 1'b1; wb_adr = 22'h22; wb_dat_i = 32'hD2D2D2D2;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL stall_resume_ack got %b want 0", wb_ack); end
        @(posedge clkcpu); #1;
        n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL resume_ack got %b want 1", wb_ack); end
        @(posedge clkcpu); #1;
        bus_idle();
        @(posedge clkcpu); #1;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack got %b want 0", wb_ack); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_d;
            case (i)
                0: exp_d = 32'hD0D0D0D0;
                1: exp_d = 32'hD1D1D1D1;
                2: exp_d = 32'hD2D2D2D2;
                default: exp_d = 32'h12345678;
            endcase
            read_classic(22'h20 + 22'(i), d, lat);
            n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL wburst_word%0d got %h want %h", i, d, exp_d); end
        end
    endtask

    task automatic test_reset_midburst();
        int lat;
        logic [31:0] d;
        write_classic(22'h30, 32'h11, 4'hF, lat);
        write_classic(22'h31, 32'h22, 4'hF, lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_cti = 3'b010;
        wb_adr = 22'h30; wb_sel = 4'hF; wb_dat_i = 32'hC0DE0000;
        wait_ack(lat);
        @(posedge clkcpu); #1;
        wb_adr = 22'h31; wb_dat_i = 32'hC0DE0001;
        #2 rst_i = 1'b1;
        #1;
        n_cmp++; if (wb_ack !== 1'b0 || wb_err !== 1'b0 || wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL async_reset got ack %b err %b dat %h want 0 0 0", wb_ack, wb_err, wb_dat_o); end
        @(posedge clkcpu); #1;
        rst_i = 1'b0;
        bus_idle();
        read_classic(22'h30, d, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL post_reset_lat got %0d want 2", lat); end
        n_cmp++; if (d !== 32'hC0DE0000) begin n_bad++; $display("FAIL rst_beat0 got %h want c0de0000", d); end
        read_classic(22'h31, d, lat);
        n_cmp++; if (d !== 32'h22) begin n_bad++; $display("FAIL rst_no_write got %h want 00000022", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_sel();
        test_read_burst();
        test_wrap();
        test_error();
        test_write_stall_abort();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_responder.md
MEM_WB_RESPONDER -- requirements
Module: mem_wb_responder

Interface
REQ-001 Parameter ADDR_W, default 14, meaning internal RAM word-address width (2^ADDR_W x 32-bit words).
REQ-002 Parameter RD_WAIT, default 1, meaning extra wait cycles before the first read ack of a cycle (range 0-7).
REQ-003 Port clkcpu  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 Port wb_cyc  in  1  wishbone cycle valid.
REQ-006 Port wb_stb  in  1  wishbone strobe.
REQ-007 Port wb_we  in  1  write enable (1 = write).
REQ-008 Port wb_sel  in  4  byte lane enables; bit n selects wb_dat_i[8n+7:8n].
REQ-009 Port wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as 000.
REQ-010 Port wb_adr  in  22  word address [23:2].
REQ-011 Port wb_dat_i  in  32  write data.
REQ-012 Port wb_dat_o  out  32  read data, valid only while wb_ack=1.
REQ-013 Port wb_ack  out  1  registered transfer acknowledge.
REQ-014 Port wb_err  out  1  registered error terminate.

Function
REQ-015 The FSM SHALL have states IDLE, LAT (read latency), XFER (acking beats), ERR.
REQ-016 A request SHALL be wb_cyc & wb_stb sampled in IDLE.
REQ-017 If wb_adr[23:ADDR_W+2] is nonzero, the block SHALL go to ERR, assert wb_err for exactly one cycle, write nothing, and return to IDLE.
REQ-018 For an in-range write, the block SHALL go directly to XFER, assert wb_ack on the next cycle, and update only the bytes enabled by wb_sel on the acked edge.
REQ-019 For an in-range read, the block SHALL spend RD_WAIT cycles in LAT before XFER; first-ack latency SHALL be RD_WAIT+1 cycles after the request is sampled.
REQ-020 Classic cycles (cti 000/111 on first beat) SHALL receive exactly one ack, then the FSM SHALL return to IDLE, with ack low for at least one cycle.
REQ-021 Bursts (cti 010 on first beat) SHALL ack one beat per cycle while wb_cyc & wb_stb hold, using an internal word counter that starts at wb_adr[ADDR_W+1:2] and increments by 1 per ack.
REQ-022 Reads in XFER SHALL prefetch counter+1 so that back-to-back beats need no extra wait cycles.
REQ-023 The counter SHALL wrap modulo 2^ADDR_W without error.
REQ-024 The beat acked while wb_cti=111 SHALL be the final beat; the FSM SHALL then return to IDLE.
REQ-025 While wb_stb=0 and wb_cyc=1 in XFER (master wait), wb_ack SHALL be 0 and the counter SHALL hold.
REQ-026 wb_cyc=0 in any non-IDLE state SHALL abort to IDLE on the next edge; ack/err SHALL be 0 from that edge, and no write SHALL occur for the unacked beat.
REQ-027 wb_ack and wb_err SHALL never both be 1, and SHALL never be 1 outside a cycle.
REQ-028 wb_we SHALL be sampled at the start of the cycle; a we change mid-burst SHALL be ignored.

Reset
REQ-029 rst_i=1 SHALL force IDLE, wb_ack=0, wb_err=0, wb_dat_o=0, and counter=0 immediately, regardless of the clock.
REQ-030 Reset SHALL NOT clear RAM contents; reset mid-burst SHALL abort the burst with no further writes.
REQ-031 After rst_i falls, the first request SHALL be accepted on the first rising edge at which it is sampled.

Verification
REQ-032 Write 0xDEADBEEF to adr 0x10 with sel=1111, then read adr 0x10 with RD_WAIT=1 -> read ack 2 cycles after the request; wb_dat_o=0xDEADBEEF.
REQ-033 Write 0x000000AA to adr 0x10 with sel=0001 over 0xDEADBEEF -> a subsequent read returns 0xDEADBEAA.
REQ-034 Preload words 0..3 = 0x100..0x103, then run a 4-beat read burst from adr 0 (cti 010,010,010,111) -> acks on 4 consecutive cycles with data 0x100..0x103, then ack low and FSM in IDLE.
REQ-035 2-beat burst from adr 2^ADDR_W-1 -> second beat accesses word 0; wb_err stays 0.
REQ-036 Access to adr 0x200000 with ADDR_W=14 -> one-cycle wb_err, no ack, RAM unchanged.
REQ-037 Write burst with stb dropped for 2 cycles mid-burst, then cyc dropped before the last beat -> no ack during the stall; only acked beats are written; FSM returns to IDLE.
